// File: rtl/hazard_ctrl_if.sv
// Decode/EX-side signal bundle for hazard_ctrl; the pipeline drives the master
// side, the controller is the slave.
`timescale 1ns/1ps

interface hazard_ctrl_if #(
  parameter int XLEN = 32
);
  logic            i_id_valid;
  logic [4:0]      i_id_rs1;
  logic [4:0]      i_id_rs2;
  logic            i_id_rs1_used;
  logic            i_id_rs2_used;
  logic [4:0]      i_id_rd;
  logic            i_id_reg_we;
  logic            i_ex_redirect;
  logic [XLEN-1:0] i_ex_target;

  logic            o_pc_sel;
  logic [XLEN-1:0] o_pc_target;
  logic            o_stall;
  logic            o_flush_if;
  logic            o_flush_id;
  logic            o_busy;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_id_rd, i_id_reg_we, i_ex_redirect, i_ex_target,
    input  o_pc_sel, o_pc_target, o_stall, o_flush_if, o_flush_id, o_busy
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
           i_id_rd, i_id_reg_we, i_ex_redirect, i_ex_target,
    output o_pc_sel, o_pc_target, o_stall, o_flush_if, o_flush_id, o_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// RAW-hazard scoreboard and redirect/flush sequencer for the non-forwarding pipeline.
// Define HAZARD_CTRL_RF_WRITE_THROUGH_EN when the register file writes before it reads.
`timescale 1ns/1ps

module hazard_ctrl #(
  parameter int REDIRECT_FLUSH = 2,
  parameter int XLEN           = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } slot_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(REDIRECT_FLUSH - 1);

  state_t     state;
  logic [2:0] cnt;
  slot_t      sb_ex, sb_mem, sb_wb;

  logic busy;
  logic hazard;
  logic match_rs1, match_rs2;

  // NOTE: every signal driven here gets a value before any condition, so no latch is inferred.
  always_comb begin
    match_rs1 = 1'b0;
    match_rs2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slot_t s;
      s = (i == 0) ? sb_ex : (i == 1) ? sb_mem : sb_wb;
`ifdef HAZARD_CTRL_RF_WRITE_THROUGH_EN
      // WB writes before the read, so its result is already visible to decode.
      if (i == 2) s.valid = 1'b0;
`endif
      if (s.valid && s.rd == bus.i_id_rs1) match_rs1 = 1'b1;
      if (s.valid && s.rd == bus.i_id_rs2) match_rs2 = 1'b1;
    end
    match_rs1 = match_rs1 && (bus.i_id_rs1 != 5'd0);
    match_rs2 = match_rs2 && (bus.i_id_rs2 != 5'd0);
  end

  assign busy   = (state == FLUSH);
  assign hazard = bus.i_id_valid &&
                  ((bus.i_id_rs1_used && match_rs1) || (bus.i_id_rs2_used && match_rs2));

  // A redirect squashes decode, and a running flush already discards it: neither stalls.
  assign bus.o_stall     = hazard && !bus.i_ex_redirect && !busy;
  assign bus.o_flush_id  = hazard || bus.i_ex_redirect;
  assign bus.o_flush_if  = bus.i_ex_redirect || busy;
  assign bus.o_pc_sel    = bus.i_ex_redirect;
  assign bus.o_pc_target = bus.i_ex_redirect ? bus.i_ex_target : {XLEN{1'b0}};
  assign bus.o_busy      = busy;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= '{valid: bus.i_id_valid && bus.i_id_reg_we && (bus.i_id_rd != 5'd0) &&
                         !bus.o_stall && !bus.o_flush_id,
                  rd:    bus.i_id_rd};
    end
  end

  // The redirect cycle itself is the first flush cycle; FLUSH covers the remaining ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else if (bus.i_ex_redirect) begin
      if (REDIRECT_FLUSH > 1) begin
        state <= FLUSH;
        cnt   <= FLUSH_RELOAD;
      end else begin
        state <= RUN;
        cnt   <= 3'd0;
      end
    end else if (state == FLUSH) begin
      if (cnt <= 3'd1) begin
        state <= RUN;
        cnt   <= 3'd0;
      end else begin
        cnt <= cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed literal cases plus random traffic
// compared every cycle against a queue-based behavioural model.
`timescale 1ns/1ps

module tb_hazard_ctrl;
  localparam int XLEN = 32;
  localparam int RF   = 2;
`ifdef HAZARD_CTRL_RF_WRITE_THROUGH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 3;
`endif

  logic i_clk = 1'b0;
  logic i_rst;

  hazard_ctrl_if #(.XLEN(XLEN)) bus ();

  hazard_ctrl #(.REDIRECT_FLUSH(RF), .XLEN(XLEN)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: issued[k] is the rd written by the instruction that entered EX k+1 cycles
  // ago (0 = nothing written); flush_left is the number of pending FLUSH cycles.
  int issued[$];
  int flush_left = 0;

  typedef struct {
    bit              stall, flush_if, flush_id, pc_sel, busy;
    logic [XLEN-1:0] target;
  } exp_t;

  function automatic bit in_flight(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    for (int k = 0; k < DEPTH && k < issued.size(); k++)
      if (issued[k] == int'(rs)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit   hz, rdr, bsy;
    hz  = bus.i_id_valid && ((bus.i_id_rs1_used && in_flight(bus.i_id_rs1)) ||
                             (bus.i_id_rs2_used && in_flight(bus.i_id_rs2)));
    rdr = bus.i_ex_redirect;
    bsy = flush_left > 0;
    e.stall    = hz && !rdr && !bsy;
    e.flush_id = hz || rdr;
    e.flush_if = rdr || bsy;
    e.pc_sel   = rdr;
    e.busy     = bsy;
    e.target   = rdr ? bus.i_ex_target : '0;
    return e;
  endfunction

  // Single compare process: check at the falling edge, then advance the model to
  // the state it will hold after the next rising edge.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst) begin
      issued     = {};
      flush_left = 0;
    end
    e = model_out();
    check("o_stall",     32'(bus.o_stall),    32'(e.stall));
    check("o_flush_if",  32'(bus.o_flush_if), 32'(e.flush_if));
    check("o_flush_id",  32'(bus.o_flush_id), 32'(e.flush_id));
    check("o_pc_sel",    32'(bus.o_pc_sel),   32'(e.pc_sel));
    check("o_busy",      32'(bus.o_busy),     32'(e.busy));
    check("o_pc_target", bus.o_pc_target,     e.target);
    if (!i_rst) begin
      issued.push_front((bus.i_id_valid && bus.i_id_reg_we && !e.flush_id) ? int'(bus.i_id_rd) : 0);
      if (issued.size() > 3) void'(issued.pop_back());
      if (bus.i_ex_redirect)  flush_left = RF - 1;
      else if (flush_left > 0) flush_left--;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    bus.i_id_valid    = 1'b0;
    bus.i_id_rs1      = 5'd0;
    bus.i_id_rs2      = 5'd0;
    bus.i_id_rs1_used = 1'b0;
    bus.i_id_rs2_used = 1'b0;
    bus.i_id_rd       = 5'd0;
    bus.i_id_reg_we   = 1'b0;
    bus.i_ex_redirect = 1'b0;
    bus.i_ex_target   = '0;
  endtask

  task automatic decode(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                        input bit u2, input logic [4:0] rd, input bit we);
    bus.i_id_valid    = 1'b1;
    bus.i_id_rs1      = rs1;
    bus.i_id_rs1_used = u1;
    bus.i_id_rs2      = rs2;
    bus.i_id_rs2_used = u2;
    bus.i_id_rd       = rd;
    bus.i_id_reg_we   = we;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  initial begin
    idle();
    i_rst = 1'b1;
    #2;
    check("reset_stall",    32'(bus.o_stall),    0);
    check("reset_flush_if", 32'(bus.o_flush_if), 0);
    check("reset_busy",     32'(bus.o_busy),     0);
    check("reset_target",   bus.o_pc_target,     0);
    tick();
    i_rst = 1'b0;
    tick();

    // addi x5,x0,1 ; add x6,x5,x5
    decode(5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    #2 check("raw_producer_stall", 32'(bus.o_stall), 0);
    tick();
    decode(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1);
    for (int n = 0; n < DEPTH; n++) begin
      #2;
      check("raw_stall",    32'(bus.o_stall),    1);
      check("raw_flush_id", 32'(bus.o_flush_id), 1);
      tick();
    end
    #2 check("raw_release", 32'(bus.o_stall), 0);
    tick();
    // Consumer of x6 right behind: proves add itself entered EX when it issued.
    decode(5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
    #2 check("raw_chain_stall", 32'(bus.o_stall), 1);
    drain();

    // x0 producer/consumer, and an unused rs2 matching a busy rd.
    decode(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
    tick();
    decode(5'd0, 1'b1, 5'd0, 1'b1, 5'd2, 1'b1);
    #2 check("x0_no_stall", 32'(bus.o_stall), 0);
    tick();
    decode(5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    decode(5'd3, 1'b1, 5'd9, 1'b0, 5'd4, 1'b1);
    #2 check("rs2_unused_no_stall", 32'(bus.o_stall), 0);
    drain();

    // Plain redirect to 0x40.
    bus.i_ex_redirect = 1'b1;
    bus.i_ex_target   = 32'h0000_0040;
    #2;
    check("rd_pc_sel",   32'(bus.o_pc_sel),   1);
    check("rd_target",   bus.o_pc_target,     32'h40);
    check("rd_flush_if", 32'(bus.o_flush_if), 1);
    check("rd_busy0",    32'(bus.o_busy),     0);
    tick();
    idle();
    #2;
    check("rd_pc_sel1",   32'(bus.o_pc_sel),   0);
    check("rd_flush_if1", 32'(bus.o_flush_if), 1);
    check("rd_busy1",     32'(bus.o_busy),     1);
    tick();
    #2;
    check("rd_flush_if2", 32'(bus.o_flush_if), 0);
    check("rd_busy2",     32'(bus.o_busy),     0);
    drain();

    // Redirect in the same cycle as a RAW hazard.
    decode(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    decode(5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
    bus.i_ex_redirect = 1'b1;
    bus.i_ex_target   = 32'h0000_0100;
    #2;
    check("rh_stall",    32'(bus.o_stall),    0);
    check("rh_flush_id", 32'(bus.o_flush_id), 1);
    check("rh_pc_sel",   32'(bus.o_pc_sel),   1);
    tick();
    idle();
    decode(5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #2 check("rh_ex_invalid", 32'(bus.o_flush_id), 0);
    decode(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("rh_producer_still_busy", 32'(bus.o_flush_id), 1);
    drain();

    // Redirect while already in FLUSH.
    bus.i_ex_redirect = 1'b1;
    bus.i_ex_target   = 32'h0000_0040;
    tick();
    bus.i_ex_target   = 32'h0000_0080;
    #2;
    check("rf_pc_sel", 32'(bus.o_pc_sel), 1);
    check("rf_target", bus.o_pc_target,   32'h80);
    check("rf_busy",   32'(bus.o_busy),   1);
    tick();
    idle();
    #2 check("rf_flush_if_held", 32'(bus.o_flush_if), 1);
    tick();
    #2 check("rf_flush_if_done", 32'(bus.o_flush_if), 0);
    drain();

    // Reset asserted in FLUSH with cnt=1.
    bus.i_ex_redirect = 1'b1;
    bus.i_ex_target   = 32'h0000_0200;
    tick();
    idle();
    #2 check("rst_pre_busy", 32'(bus.o_busy), 1);
    i_rst = 1'b1;
    #1;
    check("rst_mid_busy",     32'(bus.o_busy),     0);
    check("rst_mid_flush_if", 32'(bus.o_flush_if), 0);
    tick();
    i_rst = 1'b0;
    #2;
    check("rst_after_busy",     32'(bus.o_busy),     0);
    check("rst_after_flush_if", 32'(bus.o_flush_if), 0);
    tick();

    // Random traffic with small register indices to provoke frequent hazards.
    for (int c = 0; c < 800; c++) begin
      bus.i_id_valid    = ($urandom_range(3) != 0);
      bus.i_id_rs1      = 5'($urandom_range(7));
      bus.i_id_rs2      = 5'($urandom_range(7));
      bus.i_id_rs1_used = 1'($urandom_range(1));
      bus.i_id_rs2_used = 1'($urandom_range(1));
      bus.i_id_rd       = 5'($urandom_range(7));
      bus.i_id_reg_we   = ($urandom_range(3) != 0);
      bus.i_ex_redirect = ($urandom_range(7) == 0);
      bus.i_ex_target   = $urandom();
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
